// File: rtl/uart_transmitter_if.sv
`default_nettype none
// ============================================================================
// uart_transmitter_if : host handshake, frame config and line outputs of the
//                       UART transmitter
// Revision: 1.0
// ============================================================================
interface uart_transmitter_if;
  logic       tx_start;
  logic [7:0] data_in;
  logic       parity_en;
  logic       two_stop_bits;
  logic [1:0] word_length;
  logic       tx;
  logic       tx_ready;
  logic       tx_done;

  modport master (
    output tx_start, data_in, parity_en, two_stop_bits, word_length,
    input  tx, tx_ready, tx_done
  );

  modport slave (
    input  tx_start, data_in, parity_en, two_stop_bits, word_length,
    output tx, tx_ready, tx_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// uart_transmitter : serialises one byte per handshake into an async frame
//                    (start, 5-8 data LSB first, optional even parity, 1-2 stop)
// Revision: 1.0
// ============================================================================
module uart_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic              clk,
  input  logic              rstn,
  uart_transmitter_if.slave bus
);

  localparam int BAUD_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W      = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CYCLES - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]            wlen_q, wlen_d;
  logic                  par_en_q, par_en_d;
  logic                  two_stop_q, two_stop_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  logic                  bit_end;
  logic                  last_data;
  logic [7:0]            len_mask;

  assign bit_end   = (baud_q == BAUD_LAST);
  // Index of the final data bit is N-1 = 4 + word_length.
  assign last_data = (bit_q == {1'b1, wlen_q});

  always_comb begin
    len_mask = 8'hFF;
    case (bus.word_length)
      2'b00:   len_mask = 8'h1F;
      2'b01:   len_mask = 8'h3F;
      2'b10:   len_mask = 8'h7F;
      default: len_mask = 8'hFF;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = (state_q == S_IDLE || bit_end) ? '0 : baud_q + BAUD_ONE;
    bit_d      = bit_q;
    shift_d    = shift_q;
    wlen_d     = wlen_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    par_d      = par_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    // tx_d is the line level for the cycle after the coming edge.
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_start) begin
          shift_d    = DATA_WIDTH'(bus.data_in);
          wlen_d     = bus.word_length;
          par_en_d   = bus.parity_en;
          two_stop_d = bus.two_stop_bits;
          par_d      = ^(bus.data_in & len_mask);
          bit_d      = 3'd0;
          baud_d     = '0;
          state_d    = S_START;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (!last_data) begin
            tx_d = shift_q[1];
          end else if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = S_STOP1;
            tx_d    = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP1;
          tx_d    = 1'b1;
        end
      end
      S_STOP1: begin
        if (bit_end) begin
          tx_d = 1'b1;
          if (two_stop_q) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= '0;
      wlen_q     <= 2'b00;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wlen_q     <= wlen_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = (state_q == S_IDLE);
  assign bus.tx_done  = done_q;

endmodule
`default_nettype wire

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit half of the UART link: accepts a parallel byte through a ready/start handshake and emits one asynchronous frame (start bit, 5–8 data bits LSB first, optional even parity, one or two stop bits) on `tx`. Frame format inputs match the `uart_receiver` configuration inputs, so both ends can be driven from one shared control register. The block sits between the host-side register/FIFO logic and the TX pad.

## Interface
- `DATA_WIDTH`, 8: width of `data_in`. Fixed at 8 for this design.
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s. The bit period is `BAUD_CYCLES = CLK_FREQ / BAUD_RATE`, using integer division (10416 at the defaults). `BAUD_CYCLES` must be at least 2.

- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `tx_start` in 1: request to send. Accepted only in a cycle where `tx_ready` = 1.
- `data_in` in 8: byte to send. Sampled on the accept edge.
- `parity_en` in 1: when 1, an even-parity bit follows the data bits. Sampled on the accept edge.
- `two_stop_bits` in 1: 0 selects one stop bit, 1 selects two. Sampled on the accept edge.
- `word_length` in 2: number of data bits N. 00 = 5, 01 = 6, 10 = 7, 11 = 8. Sampled on the accept edge.
- `tx` out 1: serial line, registered. Idles high.
- `tx_ready` out 1: 1 when idle and able to accept a byte.
- `tx_done` out 1: one-cycle pulse when a frame has completed.

## Operation
- State machine states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- **IDLE**
  - `tx` = 1, `tx_ready` = 1.
  - On `tx_start` && `tx_ready`: latch `data_in` into the shift register, latch all three config inputs, clear the baud counter and bit counter, go to START, and drop `tx_ready`.
- **START**: `tx` = 0 for `BAUD_CYCLES` cycles, then go to DATA.
- **DATA**
  - `tx` = shift register bit 0 for each bit period.
  - At the end of each period, shift right and increment the bit counter.
  - After bit N−1, go to PARITY if the latched `parity_en` = 1, otherwise go to STOP1.
- **PARITY**: `tx` = XOR of the N transmitted data bits (even parity), for one period. Data bits at index N and above are ignored for both transmission and parity.
- **STOP1**: `tx` = 1 for one period. Then go to STOP2 if the latched `two_stop_bits` = 1, otherwise end the frame.
- **STOP2**: `tx` = 1 for one period, then end the frame.
- **Frame end**: return to IDLE, pulse `tx_done` for one cycle, and raise `tx_ready`.
- **Baud counter**
  - Counts 0 to `BAUD_CYCLES`−1 and wraps to 0 at the end of each bit.
  - Counts only while not in IDLE; held at 0 in IDLE.
  - Counter width is `$clog2(BAUD_CYCLES)`, with a minimum of 1.
- `tx_start` while `tx_ready` = 0 is ignored; it is neither queued nor flagged.
- Config inputs and `data_in` may change freely mid-frame without affecting the frame in progress.
- Reset values: `tx` = 1, `tx_ready` = 1, `tx_done` = 0, state IDLE, all counters 0.
- Asserting `rstn` mid-frame aborts the frame. `tx` goes to 1 asynchronously and no `tx_done` is produced.

## Timing
- Accept edge is cycle k. `tx` = 0 from cycle k+1 through k+`BAUD_CYCLES`.
- Every bit lasts exactly `BAUD_CYCLES` cycles, with no jitter and no gaps between bits.
- Frame length F = 1 + N + P + S bits, where P ∈ {0,1} and S ∈ {1,2}. The last stop-bit cycle is k + F·`BAUD_CYCLES`.
- Cycle k + F·`BAUD_CYCLES` + 1: `tx_done` = 1, `tx_ready` = 1, `tx` = 1.
- A `tx_start` in that same cycle is accepted. Back-to-back frames therefore have exactly one idle-high cycle between the last stop bit and the next start bit.
- `tx_ready` is low from cycle k+1 through k + F·`BAUD_CYCLES`.

## Test plan
All scenarios use `CLK_FREQ`=100 and `BAUD_RATE`=10, so `BAUD_CYCLES` = 10.

- **8N1**: `data_in`=0xA5, `word_length`=11, `parity_en`=0, `two_stop_bits`=0.
  - Required: `tx` sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles.
  - Required: `tx_done` at accept+101.
- **5E2**: `data_in`=0x1F, `word_length`=00, `parity_en`=1, `two_stop_bits`=1.
  - Required: start bit, five 1s, parity bit 1, two stop bits (9 bits, 90 cycles).
  - Required: `tx_done` at accept+91.
- **7E1 with upper bit set**: `data_in`=0xFF, `word_length`=10, `parity_en`=1.
  - Required: seven 1s, then parity 1, then stop. Bit 7 is never driven.
- **Back-to-back**: hold `tx_start`=1 with 0x00 then 0xFF (8N1).
  - Required: second start bit begins exactly 1 idle cycle after the first stop bit ends.
  - Required: each frame produces exactly one `tx_done`.
- **Busy ignore**: pulse `tx_start` with 0x33 mid-frame.
  - Required: current frame unchanged and no extra frame sent.
  - Required: changing `word_length` mid-frame does not alter the frame length.
- **Reset mid-frame**: drop `rstn` during the DATA state.
  - Required: `tx`=1, `tx_ready`=1, `tx_done`=0 immediately.
  - Required: after release, a new 0x5A frame transmits correctly.
